ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between a host controller and the PS/2 transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (inhibit, request, shift, ack)
// Open-drain lines are driven through *_oe; all control outputs are registered.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic ps2clk_oe,
    output logic ps2data_oe,
    ps2_host_tx_if.slave tx
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t            state;
    logic              clk_s1, clk_s2, clk_prev;
    logic              dat_s1, dat_s2;
    logic [7:0]        byte_q;
    logic              parity_q;
    logic [INH_W-1:0]  inh_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        edge_cnt;
    logic              clk_oe_q, data_oe_q, busy_q, done_q, error_q;

    logic fall;
    logic timed;
    logic timeout_hit;

    assign fall        = clk_prev & ~clk_s2;
    assign timed       = (state == S_REQUEST) || (state == S_SHIFT) ||
                         (state == S_ACK) || (state == S_RELEASE);
    assign timeout_hit = timed && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            clk_prev  <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            edge_cnt  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            clk_s1   <= ps2clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2data_in;
            dat_s2   <= dat_s1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;

            if (timed) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // The bus timeout overrides whatever phase the frame is in.
            if (timeout_hit) begin
                state     <= S_IDLE;
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                busy_q    <= 1'b0;
                error_q   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx.tx_start) begin
                            byte_q    <= tx.tx_data;
                            parity_q  <= ~^tx.tx_data;
                            inh_cnt   <= '0;
                            to_cnt    <= '0;
                            edge_cnt  <= '0;
                            clk_oe_q  <= 1'b1;
                            data_oe_q <= (INHIBIT_CYCLES == 1);
                            busy_q    <= 1'b1;
                            state     <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        inh_cnt <= inh_cnt + 1'b1;
                        // Start bit is registered one cycle early so it shows in the last inhibit cycle.
                        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
                            data_oe_q <= 1'b1;
                        end
                        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b1;
                            state     <= S_REQUEST;
                        end
                    end
                    S_REQUEST: begin
                        edge_cnt <= '0;
                        state    <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (edge_cnt < 4'd8) begin
                                data_oe_q <= ~byte_q[edge_cnt[2:0]];
                            end else if (edge_cnt == 4'd8) begin
                                data_oe_q <= ~parity_q;
                            end else begin
                                data_oe_q <= 1'b0;
                                state     <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (!dat_s2) begin
                                state <= S_RELEASE;
                            end else begin
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (clk_s2 && dat_s2) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ps2clk_oe  = clk_oe_q;
    assign ps2data_oe = data_oe_q;
    assign tx.busy    = busy_q;
    assign tx.done    = done_q;
    assign tx.error   = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2clk_oe, ps2data_oe;
    logic clk_line, data_line;

    always #5 clk = ~clk;

    assign clk_line  = dev_clk & ~ps2clk_oe;
    assign data_line = dev_data & ~ps2data_oe;

    ps2_host_tx_if txif();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2clk_in  (clk_line),
        .ps2data_in (data_line),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe),
        .tx         (txif)
    );

    typedef struct {
        bit          is_err;
        bit          has_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] got_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          err_cyc = 0;
    int          rel_cyc = 0;
    int          inh_run = 0;
    int          inh_dat = 0;
    int          last_inh_len = 0;
    int          last_inh_dat = 0;
    logic        rel_data_oe = 1'b0;
    logic        prev_clk_oe = 1'b0;
    logic        prev_pulse = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=expired expected=event", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Inhibit window tracker: length of each clock-low run and start-bit overlap.
    always @(negedge clk) begin
        if (ps2clk_oe && !prev_clk_oe) begin
            inh_run <= 1;
            inh_dat <= ps2data_oe ? 1 : 0;
        end else if (ps2clk_oe) begin
            inh_run <= inh_run + 1;
            inh_dat <= inh_dat + (ps2data_oe ? 1 : 0);
        end
        if (!ps2clk_oe && prev_clk_oe && rst) begin
            last_inh_len <= inh_run;
            last_inh_dat <= inh_dat;
            rel_cyc      <= cyc;
            rel_data_oe  <= ps2data_oe;
        end
        prev_clk_oe <= ps2clk_oe;
    end

    always @(negedge clk) begin
        if (rst && (txif.done || txif.error)) begin
            check("pulse_exclusive", txif.done & txif.error, 0);
            check("busy_at_pulse", txif.busy, 0);
            check("pulse_width", prev_pulse, 0);
            check("lines_released", {ps2clk_oe, ps2data_oe}, 0);
            if (txif.error) err_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got done=%0d error=%0d expected=none", txif.done, txif.error);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_is_error", txif.error, mon_e.is_err);
                if (mon_e.has_frame) begin
                    if (got_q.size() == 0) fail_now("frame_captured");
                    else check("frame_bits", got_q.pop_front(), mon_e.frame);
                end
            end
        end
        prev_pulse = rst && (txif.done || txif.error);
    end

    task automatic push_exp(input bit is_err, input bit has_frame, input logic [10:0] frame);
        exp_t e;
        e.is_err = is_err;
        e.has_frame = has_frame;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1 txif.tx_data = d;
        txif.tx_start = 1'b1;
        @(posedge clk);
        #1 txif.tx_start = 1'b0;
        check("busy_after_start", txif.busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!txif.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_idle");
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic dev_wait_request(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ps2clk_oe && ps2data_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("request_seen");
    endtask

    task automatic dev_pulse();
        repeat (HALF) @(posedge clk);
        #1 dev_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 dev_clk = 1'b1;
    endtask

    task automatic dev_frame(input bit ack);
        logic [10:0] f;
        bit ok;
        dev_wait_request(ok);
        if (ok) begin
            repeat (HALF) @(posedge clk);
            #1 f[0] = data_line;
            for (int i = 1; i <= 10; i++) begin
                dev_pulse();
                f[i] = data_line;
            end
            got_q.push_back(f);
            repeat (HALF / 2) @(posedge clk);
            #1 dev_data = ack ? 1'b0 : 1'b1;
            dev_pulse();
            repeat (3) @(posedge clk);
            #1 dev_data = 1'b1;
        end
    endtask

    task automatic check_inhibit();
        check("inhibit_len", last_inh_len, INH);
        check("start_bit_cycles_in_inhibit", last_inh_dat, 1);
        check("data_oe_at_release", rel_data_oe, 1);
    endtask

    initial begin
        bit ok;
        txif.tx_data = 8'h00;
        txif.tx_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_oe", ps2clk_oe, 0);
        check("rst_data_oe", ps2data_oe, 0);
        check("rst_busy", txif.busy, 0);
        check("rst_done", txif.done, 0);
        check("rst_error", txif.error, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // 0xED with a second start (0x55) issued while busy
        push_exp(1'b0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
        send(8'hED);
        repeat (4) @(posedge clk);
        #1 txif.tx_data = 8'h55;
        txif.tx_start = 1'b1;
        @(posedge clk);
        #1 txif.tx_start = 1'b0;
        dev_frame(1'b1);
        wait_idle(400);
        check_inhibit();
        repeat (20) @(negedge clk);
        check("ignored_start_stays_idle", txif.busy, 0);

        push_exp(1'b0, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0});
        send(8'h01);
        dev_frame(1'b1);
        wait_idle(400);
        check_inhibit();

        // device NACK
        push_exp(1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0});
        send(8'hA5);
        dev_frame(1'b0);
        wait_idle(400);
        check("nack_lines", {ps2clk_oe, ps2data_oe}, 0);

        // silent device
        push_exp(1'b1, 1'b0, 11'h000);
        send(8'h3C);
        wait_idle(TO + 200);
        check("timeout_latency", err_cyc - rel_cyc, TO);
        check("timeout_lines", {ps2clk_oe, ps2data_oe}, 0);

        // reset mid-frame after the 4th falling edge
        send(8'h00);
        dev_wait_request(ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) dev_pulse();
            repeat (HALF) @(posedge clk);
            #1 dev_clk = 1'b0;
            repeat (6) @(posedge clk);
            #2;
            check("pre_reset_data_oe", ps2data_oe, 1);
            rst = 1'b0;
            #1;
            check("reset_clk_oe", ps2clk_oe, 0);
            check("reset_data_oe", ps2data_oe, 0);
            check("reset_busy", txif.busy, 0);
            dev_clk = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            repeat (3) @(negedge clk);
            check("no_pulse_on_reset_exit", txif.done | txif.error, 0);
        end

        push_exp(1'b0, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
        send(8'hF4);
        dev_frame(1'b1);
        wait_idle(400);
        check_inhibit();

        check("frames_left", got_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
